// File: rtl/disp_arb_pkg.sv
// Shared types and round-robin helpers for the display-share arbiter.
// Requester indices are carried at a fixed 3-bit width (up to 8 requesters).
package disp_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    OWN,
    SWITCH
  } arb_state_t;

  localparam logic [3:0] BLANK_LES = 4'hF;
  localparam int         MAX_REQ   = 8;
  localparam int         IDX_W     = 3;

  // First asserted request at ptr, ptr+1, ... wrapping at nreq.
  // Returns ptr unchanged when nothing is requesting.
  function automatic logic [IDX_W-1:0] rr_pick(
    input logic [MAX_REQ-1:0] req_vec,
    input logic [IDX_W-1:0]   ptr,
    input int                 nreq
  );
    logic [IDX_W-1:0] idx;
    logic             found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int i = 0; i < MAX_REQ; i++) begin
      idx = IDX_W'((int'(ptr) + i) % nreq);
      if (!found && (i < nreq) && req_vec[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  function automatic logic [IDX_W-1:0] rr_inc(
    input logic [IDX_W-1:0] idx,
    input int               nreq
  );
    return IDX_W'((int'(idx) + 1) % nreq);
  endfunction

endpackage

// File: rtl/disp_scan_timer.sv
// Free-running digit-scan prescaler: registered scan_tick on the last
// prescaler cycle, and a 2-bit scan select that advances the cycle after.
module disp_scan_timer
  import disp_arb_pkg::*;
#(
  parameter int SCAN_DIV = 131072
) (
  input  logic       clk,
  input  logic       rst,
  output logic [1:0] scan,
  output logic       scan_tick
);

  localparam int            PW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(SCAN_DIV - 1);

  logic [PW-1:0] pre_reg;
  logic [PW-1:0] pre_next;
  logic          tick_reg;
  logic [1:0]    scan_reg;

  always_comb begin
    pre_next = (pre_reg == LAST) ? '0 : pre_reg + 1'b1;
  end

  // The tick is registered against the next prescaler value so that it is
  // high exactly while the prescaler register holds LAST (constant when
  // SCAN_DIV = 1) and is still 0 straight out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_reg  <= '0;
      tick_reg <= 1'b0;
      scan_reg <= 2'd0;
    end else begin
      pre_reg  <= pre_next;
      tick_reg <= (pre_next == LAST);
      if (tick_reg) begin
        scan_reg <= scan_reg + 2'd1;
      end
    end
  end

  assign scan      = scan_reg;
  assign scan_tick = tick_reg;

endmodule

// File: rtl/display_share_arbiter.sv
// Round-robin owner arbitration of the shared 4-digit display with minimum
// dwell, a blanking gap between owners and a built-in digit-scan timer.
module display_share_arbiter
  import disp_arb_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int SCAN_DIV = 131072,
  parameter int HOLD_CYC = 50000000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [16*NREQ-1:0]   req_hexs,
  input  logic [4*NREQ-1:0]    req_points,
  input  logic [4*NREQ-1:0]    req_les,
  output logic [NREQ-1:0]      grant,
  output logic                 busy,
  output logic [15:0]          hexs,
  output logic [3:0]           points,
  output logic [3:0]           LEs,
  output logic [1:0]           scan,
  output logic                 scan_tick
);

  localparam int            HW        = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYC - 1);

  arb_state_t        state_reg;
  logic [IDX_W-1:0]  rr_ptr_reg;
  logic [IDX_W-1:0]  owner_reg;
  logic [HW-1:0]     hold_cnt_reg;
  logic [NREQ-1:0]   grant_reg;
  logic              busy_reg;
  logic [15:0]       hexs_reg;
  logic [3:0]        points_reg;
  logic [3:0]        les_reg;

  logic [15:0]       hex_slice   [MAX_REQ];
  logic [3:0]        point_slice [MAX_REQ];
  logic [3:0]        le_slice    [MAX_REQ];
  logic [MAX_REQ-1:0] req_pad;
  logic [IDX_W-1:0]  pick;
  logic              any_req;
  logic              owner_req;
  logic              others_req;
  logic              tick;

  // Unused slots above NREQ read as zero so the owner mux is always full-width.
  genvar gi;
  generate
    for (gi = 0; gi < MAX_REQ; gi++) begin : g_slice
      if (gi < NREQ) begin : g_live
        assign hex_slice[gi]   = req_hexs[16*gi +: 16];
        assign point_slice[gi] = req_points[4*gi +: 4];
        assign le_slice[gi]    = req_les[4*gi +: 4];
      end else begin : g_pad
        assign hex_slice[gi]   = 16'h0000;
        assign point_slice[gi] = 4'h0;
        assign le_slice[gi]    = 4'h0;
      end
    end
  endgenerate

  assign req_pad    = MAX_REQ'(req);
  assign any_req    = |req;
  assign pick       = rr_pick(req_pad, rr_ptr_reg, NREQ);
  assign owner_req  = req_pad[owner_reg];
  assign others_req = |(req & ~grant_reg);

  disp_scan_timer #(
    .SCAN_DIV (SCAN_DIV)
  ) u_scan_timer (
    .clk       (clk),
    .rst       (rst),
    .scan      (scan),
    .scan_tick (tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      rr_ptr_reg   <= '0;
      owner_reg    <= '0;
      hold_cnt_reg <= '0;
      grant_reg    <= '0;
      busy_reg     <= 1'b0;
      hexs_reg     <= 16'h0000;
      points_reg   <= 4'h0;
      les_reg      <= BLANK_LES;
    end else begin
      case (state_reg)
        IDLE: begin
          hexs_reg   <= 16'h0000;
          points_reg <= 4'h0;
          les_reg    <= BLANK_LES;
          grant_reg  <= '0;
          busy_reg   <= 1'b0;
          if (any_req) begin
            state_reg    <= OWN;
            owner_reg    <= pick;
            grant_reg    <= NREQ'(1) << pick;
            busy_reg     <= 1'b1;
            rr_ptr_reg   <= rr_inc(pick, NREQ);
            hold_cnt_reg <= '0;
          end
        end

        OWN: begin
          hexs_reg   <= hex_slice[owner_reg];
          points_reg <= point_slice[owner_reg];
          les_reg    <= le_slice[owner_reg];
          if (hold_cnt_reg != HOLD_LAST) begin
            hold_cnt_reg <= hold_cnt_reg + 1'b1;
          end
          // Release on drop, or pre-empt once the dwell has expired and
          // someone else is waiting.
          if (!owner_req || ((hold_cnt_reg == HOLD_LAST) && others_req)) begin
            state_reg <= SWITCH;
            grant_reg <= '0;
            busy_reg  <= 1'b0;
            les_reg   <= BLANK_LES;
          end
        end

        SWITCH: begin
          les_reg   <= BLANK_LES;
          grant_reg <= '0;
          busy_reg  <= 1'b0;
          if (tick) begin
            if (any_req) begin
              state_reg    <= OWN;
              owner_reg    <= pick;
              grant_reg    <= NREQ'(1) << pick;
              busy_reg     <= 1'b1;
              rr_ptr_reg   <= rr_inc(pick, NREQ);
              hold_cnt_reg <= '0;
            end else begin
              state_reg  <= IDLE;
              hexs_reg   <= 16'h0000;
              points_reg <= 4'h0;
            end
          end
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign grant     = grant_reg;
  assign busy      = busy_reg;
  assign hexs      = hexs_reg;
  assign points    = points_reg;
  assign LEs       = les_reg;
  assign scan_tick = tick;

endmodule

// File: tb/tb_display_share_arbiter.sv
// Scenario bench for display_share_arbiter (NREQ=4, SCAN_DIV=4, HOLD_CYC=8).
module tb_display_share_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req = 4'b0000;
  logic [63:0] req_hexs   = {16'hD3D3, 16'hC2C2, 16'hB1B1, 16'hA0A0};
  logic [15:0] req_points = {4'h8, 4'h4, 4'h2, 4'h1};
  logic [15:0] req_les    = {4'h1, 4'h2, 4'h4, 4'h0};
  logic [3:0]  grant;
  logic        busy;
  logic [15:0] hexs;
  logic [3:0]  points;
  logic [3:0]  LEs;
  logic [1:0]  scan;
  logic        scan_tick;

  int n_cmp = 0;
  int n_err = 0;
  int cyc;

  logic [15:0] hex_q[$];
  logic [3:0]  grant_q[$];

  display_share_arbiter #(
    .NREQ     (4),
    .SCAN_DIV (4),
    .HOLD_CYC (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_hexs   (req_hexs),
    .req_points (req_points),
    .req_les    (req_les),
    .grant      (grant),
    .busy       (busy),
    .hexs       (hexs),
    .points     (points),
    .LEs        (LEs),
    .scan       (scan),
    .scan_tick  (scan_tick)
  );

  always #5 clk = ~clk;

  // Clock edges since reset release: prescaler position is cyc mod 4.
  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_tick_then_step(input string name);
    int n = 0;
    while (scan_tick !== 1'b1 && n < 16) begin
      step();
      n++;
    end
    n_cmp++;
    if (scan_tick !== 1'b1) begin
      n_err++;
      $display("FAIL %s_tick_timeout: scan_tick=%b expected 1 within 16 cycles", name, scan_tick);
    end
    step();
  endtask

  task automatic go_idle();
    req = 4'b0000;
    step();
    wait_tick_then_step("go_idle");
  endtask

  task automatic test_reset();
    logic [15:0] exp_hex;
    rst = 1'b0;
    req = 4'b1111;
    step();
    step();
    n_cmp++; if (grant !== 4'b0000) begin n_err++; $display("FAIL reset_grant: got %b expected 0000", grant); end
    n_cmp++; if (LEs !== 4'hF) begin n_err++; $display("FAIL reset_les: got %h expected F", LEs); end
    n_cmp++; if (scan !== 2'd0) begin n_err++; $display("FAIL reset_scan: got %0d expected 0", scan); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_cmp++; if (hexs !== 16'h0000) begin n_err++; $display("FAIL reset_hexs: got %h expected 0000", hexs); end
    n_cmp++; if (scan_tick !== 1'b0) begin n_err++; $display("FAIL reset_tick: got %b expected 0", scan_tick); end
    rst = 1'b1;
    hex_q.push_back(16'hA0A0);
    step();
    n_cmp++; if (grant !== 4'b0001) begin n_err++; $display("FAIL reset_first_grant: got %b expected 0001", grant); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL reset_first_busy: got %b expected 1", busy); end
    step();
    exp_hex = hex_q.pop_front();
    n_cmp++; if (hexs !== exp_hex) begin n_err++; $display("FAIL reset_first_hexs: got %h expected %h", hexs, exp_hex); end
    n_cmp++; if (points !== 4'h1) begin n_err++; $display("FAIL reset_first_points: got %h expected 1", points); end
    n_cmp++; if (LEs !== 4'h0) begin n_err++; $display("FAIL reset_first_les: got %h expected 0", LEs); end
    $display("test_reset: grant=%b hexs=%h", grant, hexs);
    go_idle();
  endtask

  task automatic test_scan();
    int   ticks = 0;
    logic exp_tick;
    logic [1:0] exp_scan;
    req = 4'b0000;
    for (int i = 0; i < 16; i++) begin
      step();
      exp_tick = (cyc % 4 == 3);
      exp_scan = 2'((cyc / 4) % 4);
      if (scan_tick === 1'b1) ticks++;
      n_cmp++; if (scan_tick !== exp_tick) begin n_err++; $display("FAIL scan_tick_c%0d: got %b expected %b", cyc, scan_tick, exp_tick); end
      n_cmp++; if (scan !== exp_scan) begin n_err++; $display("FAIL scan_value_c%0d: got %0d expected %0d", cyc, scan, exp_scan); end
    end
    n_cmp++; if (ticks != 4) begin n_err++; $display("FAIL scan_tick_count: got %0d expected 4", ticks); end
    n_cmp++; if (grant !== 4'b0000) begin n_err++; $display("FAIL scan_idle_grant: got %b expected 0000", grant); end
    $display("test_scan: %0d ticks in 16 cycles", ticks);
  endtask

  task automatic test_lone_owner();
    logic [15:0] exp_hex;
    req = 4'b0100;
    step();
    for (int i = 0; i < 40; i++) begin
      n_cmp++; if (grant !== 4'b0100) begin n_err++; $display("FAIL lone_grant_c%0d: got %b expected 0100", i, grant); end
      step();
    end
    req_hexs[47:32] = 16'h1234;
    hex_q.push_back(16'h1234);
    step();
    exp_hex = hex_q.pop_front();
    n_cmp++; if (hexs !== exp_hex) begin n_err++; $display("FAIL lone_live_hexs: got %h expected %h", hexs, exp_hex); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL lone_busy: got %b expected 1", busy); end
    $display("test_lone_owner: grant=%b hexs=%h", grant, hexs);
    go_idle();
  endtask

  task automatic test_early_release();
    req = 4'b0010;
    step();
    n_cmp++; if (grant !== 4'b0010) begin n_err++; $display("FAIL early_grant: got %b expected 0010", grant); end
    step();
    step();
    req = 4'b0000;
    step();
    n_cmp++; if (grant !== 4'b0000) begin n_err++; $display("FAIL early_switch_grant: got %b expected 0000", grant); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL early_switch_busy: got %b expected 0", busy); end
    n_cmp++; if (LEs !== 4'hF) begin n_err++; $display("FAIL early_switch_les: got %h expected F", LEs); end
    n_cmp++; if (hexs !== 16'hB1B1) begin n_err++; $display("FAIL early_switch_hexs: got %h expected B1B1", hexs); end
    wait_tick_then_step("early");
    n_cmp++; if (hexs !== 16'h0000) begin n_err++; $display("FAIL early_idle_hexs: got %h expected 0000", hexs); end
    n_cmp++; if (LEs !== 4'hF) begin n_err++; $display("FAIL early_idle_les: got %h expected F", LEs); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL early_idle_busy: got %b expected 0", busy); end
    n_cmp++; if (points !== 4'h0) begin n_err++; $display("FAIL early_idle_points: got %h expected 0", points); end
    $display("test_early_release: hexs=%h LEs=%h busy=%b", hexs, LEs, busy);
  endtask

  task automatic test_preempt();
    logic [3:0]  exp_grant;
    logic [15:0] exp_hex;
    int          n;
    int          d;
    req = 4'b0001;
    step();
    for (int k = 0; k < 8; k++) begin
      n_cmp++; if (grant !== 4'b0001) begin n_err++; $display("FAIL preempt_hold_k%0d: got %b expected 0001", k, grant); end
      if (k == 3) req = 4'b1101;
      step();
    end
    n_cmp++; if (grant !== 4'b0000) begin n_err++; $display("FAIL preempt_switch_grant: got %b expected 0000", grant); end
    n_cmp++; if (LEs !== 4'hF) begin n_err++; $display("FAIL preempt_switch_les: got %h expected F", LEs); end
    grant_q.push_back(4'b0100);
    grant_q.push_back(4'b1000);
    grant_q.push_back(4'b0001);
    for (int t = 0; t < 3; t++) begin
      n = 0;
      while (grant === 4'b0000 && n < 20) begin
        n_cmp++; if (LEs !== 4'hF) begin n_err++; $display("FAIL preempt_gap_les_t%0d: got %h expected F", t, LEs); end
        step();
        n++;
      end
      exp_grant = grant_q.pop_front();
      n_cmp++; if (grant !== exp_grant) begin n_err++; $display("FAIL preempt_order_t%0d: got %b expected %b", t, grant, exp_grant); end
      $display("grant transaction %0d: grant=%b", t, grant);
      if (t < 2) begin
        if (t == 0) hex_q.push_back(16'h1234);
        d = 0;
        while (grant === exp_grant && d < 40) begin
          step();
          d++;
          if (t == 0 && d == 1) begin
            exp_hex = hex_q.pop_front();
            n_cmp++; if (hexs !== exp_hex) begin n_err++; $display("FAIL preempt_owner2_hexs: got %h expected %h", hexs, exp_hex); end
          end
        end
        n_cmp++; if (d != 8) begin n_err++; $display("FAIL preempt_dwell_t%0d: got %0d cycles expected 8", t, d); end
      end
    end
  endtask

  task automatic test_reset_mid_own();
    #2;
    rst = 1'b0;
    #1;
    n_cmp++; if (grant !== 4'b0000) begin n_err++; $display("FAIL async_grant: got %b expected 0000", grant); end
    n_cmp++; if (LEs !== 4'hF) begin n_err++; $display("FAIL async_les: got %h expected F", LEs); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL async_busy: got %b expected 0", busy); end
    n_cmp++; if (hexs !== 16'h0000) begin n_err++; $display("FAIL async_hexs: got %h expected 0000", hexs); end
    n_cmp++; if (scan !== 2'd0) begin n_err++; $display("FAIL async_scan: got %0d expected 0", scan); end
    step();
    rst = 1'b1;
    step();
    n_cmp++; if (grant !== 4'b0001) begin n_err++; $display("FAIL async_restart_grant: got %b expected 0001", grant); end
    $display("test_reset_mid_own: restart grant=%b", grant);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_scan();
    test_lone_owner();
    test_early_release();
    test_preempt();
    test_reset_mid_own();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/display_share_arbiter.md
Name: display_share_arbiter

Overview:
- Shares the single 4-digit seven-segment display path between NREQ requesters (ALU result, operands, status, ...) using a req/grant handshake with round-robin fairness and a minimum dwell time.
- Generates the digit-scan select and a scan tick, so the display driver no longer needs its own free-running divider.
- Sits between the requesting datapath blocks and the display synchroniser/decoder: hexs, points, LEs and scan feed the existing display path directly.

Parameters:
- NREQ, 4, number of requesters (2..8).
- SCAN_DIV, 131072, clk cycles per digit-scan step.
- HOLD_CYC, 50000000, minimum clk cycles an owner keeps the display while others wait.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset (rst=0 resets).
- req  in  NREQ  request per requester; level-held while wanting the display.
- req_hexs  in  16*NREQ  four hex digits per requester; slice i = [16i+15:16i].
- req_points  in  4*NREQ  decimal points per requester.
- req_les  in  4*NREQ  per-digit blank (1 = blank) per requester.
- grant  out  NREQ  one-hot current owner; all zero when there is no owner.
- busy  out  1  1 while any owner is granted.
- hexs  out  16  digits to the display path.
- points  out  4  decimal points to the display path.
- LEs  out  4  blanks to the display path.
- scan  out  2  digit select, 0..3.
- scan_tick  out  1  one-cycle pulse on the last prescaler cycle.

Behaviour:
- Reset values: grant=0, busy=0, hexs=0, points=0, LEs=4'hF, scan=0, scan_tick=0, prescaler=0, hold_cnt=0, rr_ptr=0, state=IDLE.
- Scan timer:
  - Prescaler counts 0..SCAN_DIV-1 and wraps to 0.
  - scan_tick=1 in the cycle the prescaler equals SCAN_DIV-1.
  - scan increments on the cycle after the tick and wraps 3->0.
  - Free-running in every state.
- Round-robin pick: the first asserted req at index rr_ptr, rr_ptr+1, ... mod NREQ. When an owner is granted, rr_ptr <= owner+1 mod NREQ.
- IDLE:
  - Outputs hexs=0, points=0, LEs=4'hF, grant=0.
  - If any req is high, perform the pick, go to OWN and assert grant on the next cycle.
- OWN:
  - grant is one-hot on the owner, busy=1.
  - hexs, points and LEs are registered copies of the owner's slices, with 1-cycle latency; they follow live input changes.
  - hold_cnt increments each cycle and saturates at HOLD_CYC-1.
  - Owner drops req: go to SWITCH next cycle, regardless of hold_cnt.
  - hold_cnt = HOLD_CYC-1 and another req is high: go to SWITCH (pre-emption).
  - Otherwise stay in OWN; a lone requester keeps the display indefinitely.
- SWITCH (anti-ghosting blank):
  - grant=0, busy=0, LEs=4'hF, hexs and points hold their last values.
  - Leave on the cycle scan_tick=1.
  - If any req is high at that cycle, perform the pick and go to OWN, with hold_cnt cleared.
  - Otherwise go to IDLE.
- A requester that raises and drops req entirely within SWITCH or IDLE before a pick is not granted.
- Simultaneous requests: the pick is strictly by rr_ptr order. A pre-empted owner re-requesting is last in order.
- Asynchronous reset mid-operation: everything returns to reset values immediately. After release, the first pick starts from index 0.
- SCAN_DIV=1: scan_tick is constantly 1 and scan advances every cycle. Legal.

Decomposition:
- Package disp_arb_pkg holds:
  - the state enum {IDLE, OWN, SWITCH};
  - BLANK_LES = 4'hF;
  - a function for the round-robin next index.
- One sub-module, disp_scan_timer: prescaler, scan_tick and scan counter, parameterised by SCAN_DIV, with the same clk/rst.

Test Plan (NREQ=4, SCAN_DIV=4, HOLD_CYC=8):
- Reset: hold rst=0 with req=4'b1111 -> grant=0, LEs=4'hF, scan=0. Release rst -> grant=4'b0001 after 1 cycle, and hexs=req_hexs[15:0] one cycle later.
- Scan: run 16 cycles in IDLE -> scan_tick pulses every 4th cycle; scan sequence 0,1,2,3,0; no glitches.
- Lone owner: req=4'b0100 held for 40 cycles -> grant stays 4'b0100 and is never pre-empted. Changing req_hexs[47:32] to 16'h1234 gives hexs=16'h1234 1 cycle later.
- Pre-emption and round-robin: req0 is owner, req2 and req3 rise at cycle 3 -> req0 keeps the display until hold_cnt=7, then SWITCH with LEs=4'hF until scan_tick. Then grant=4'b0100, later 4'b1000, then back to req0 if it is still requesting.
- Early release: the owner drops req at hold_cnt=2 with no other requests -> SWITCH, then IDLE at the next scan_tick. Final outputs: hexs=0, LEs=4'hF, busy=0.
- Reset mid-OWN: assert rst=0 asynchronously between clock edges -> grant=0 and LEs=4'hF without waiting for a clk edge. After release, the pick restarts at req0.
